// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the W x W sequential multiplier controller.
// Holds the FSM state enum, per-step operand-half selection and shift tables.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PP   = 2'd1,
    DONE = 2'd2
  } state_e;

  // Step names: which halves of A and B feed the shared core.
  typedef enum logic [1:0] {
    STEP_LL = 2'd0,  // AL * BL
    STEP_HL = 2'd1,  // AH * BL
    STEP_LH = 2'd2,  // AL * BH
    STEP_HH = 2'd3   // AH * BH
  } step_e;

  // Bit i set: step i takes the high half of that operand.
  localparam logic [3:0] STEP_A_HI = 4'b1010;
  localparam logic [3:0] STEP_B_HI = 4'b1100;

  // Shift per step in units of HW, two bits per step, step0 in the LSBs.
  localparam logic [7:0] SHIFT_TBL = 8'b10_01_01_00;

  // Index of the first set bit of m at or above start; 4 when there is none.
  function automatic logic [2:0] first_from(logic [3:0] m, logic [2:0] start);
    logic [2:0] r;
    r = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (3'(i) >= start)) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Job and result handshake bundle between producer, controller and consumer.
// A transfer happens on a rising edge where valid and ready are both 1; the
// source holds valid and data stable until then, and ready never waits on valid.
interface mul_seq_ctrl_if #(
  parameter int W = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p
  );
endinterface

// File: rtl/mul_seq_opsel.sv
// Operand-half selection for the shared (W/2)x(W/2) core, plus shift and next step.
// With MUL_SEQ_SKIP_ZERO_EN the next step skips partial products masked off as zero.
module mul_seq_opsel
  import mul_seq_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           active,
  input  logic [1:0]     step,
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
`ifdef MUL_SEQ_SKIP_ZERO_EN
  input  logic [3:0]     mask,
`endif
  output logic [W/2-1:0] mul_a,
  output logic [W/2-1:0] mul_b,
  output logic [1:0]     shift_units,
  output logic [1:0]     next_step,
  output logic           last
);
  localparam int HW = W / 2;

  // Core inputs are parked at zero outside the partial-product phase.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (active) begin
      mul_a = STEP_A_HI[step] ? op_a[W-1:HW] : op_a[HW-1:0];
      mul_b = STEP_B_HI[step] ? op_b[W-1:HW] : op_b[HW-1:0];
    end
  end

  assign shift_units = SHIFT_TBL[{step, 1'b0} +: 2];

`ifdef MUL_SEQ_SKIP_ZERO_EN
  logic [2:0] nxt;
  assign nxt       = first_from(mask, {1'b0, step} + 3'd1);
  assign next_step = nxt[1:0];
  assign last      = nxt[2];
`else
  assign next_step = step + 2'd1;
  assign last      = (step == STEP_HH);
`endif

endmodule

// File: rtl/mul_seq_ctrl.sv
// W x W multiplier built from four passes through one external (W/2)x(W/2) core.
// Optional MUL_SEQ_SKIP_ZERO_EN skips partial products whose operand halves are zero.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_seq_ctrl_if.slave  bus,
  output logic           busy,
  output logic [W/2-1:0] mul_a,
  output logic [W/2-1:0] mul_b,
  input  logic [W-1:0]   mul_p,
  output state_e         dbg_state
);
  localparam int HW = W / 2;

  state_e         state_q, state_d;
  logic [1:0]     step_q, step_d;
  logic [W-1:0]   a_q, b_q;
  logic [2*W-1:0] acc_q, acc_d, p_q, pp_shifted;
  logic [1:0]     shift_units, next_step;
  logic           last, accept, acc_en;

`ifdef MUL_SEQ_SKIP_ZERO_EN
  logic [3:0] mask_q, in_mask;
  logic [2:0] first;
  // Mask bit i: both halves selected by step i are nonzero.
  assign in_mask = {(|bus.in_a[W-1:HW]) && (|bus.in_b[W-1:HW]),
                    (|bus.in_a[HW-1:0]) && (|bus.in_b[W-1:HW]),
                    (|bus.in_a[W-1:HW]) && (|bus.in_b[HW-1:0]),
                    (|bus.in_a[HW-1:0]) && (|bus.in_b[HW-1:0])};
  assign first = first_from(in_mask, 3'd0);
`endif

  mul_seq_opsel #(.W(W)) u_opsel (
    .active      (state_q == PP),
    .step        (step_q),
    .op_a        (a_q),
    .op_b        (b_q),
`ifdef MUL_SEQ_SKIP_ZERO_EN
    .mask        (mask_q),
`endif
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .shift_units (shift_units),
    .next_step   (next_step),
    .last        (last)
  );

  always_comb begin
    pp_shifted = '0;
    case (shift_units)
      2'd1:    pp_shifted = {{W{1'b0}}, mul_p} << HW;
      2'd2:    pp_shifted = {{W{1'b0}}, mul_p} << W;
      default: pp_shifted = {{W{1'b0}}, mul_p};
    endcase
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    accept  = 1'b0;
    acc_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept = 1'b1;
`ifdef MUL_SEQ_SKIP_ZERO_EN
          if (first[2]) begin
            state_d = DONE;
          end else begin
            state_d = PP;
            step_d  = first[1:0];
          end
`else
          state_d = PP;
          step_d  = 2'd0;
`endif
        end
      end
      PP: begin
        acc_en = 1'b1;
        if (last) state_d = DONE;
        else      step_d  = next_step;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sum is modulo 2^(2W); an approximate core may make it wrap.
  always_comb begin
    acc_d = acc_q;
    if (accept)      acc_d = '0;
    else if (acc_en) acc_d = acc_q + pp_shifted;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
`ifdef MUL_SEQ_SKIP_ZERO_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      if (accept) begin
        a_q <= bus.in_a;
        b_q <= bus.in_b;
`ifdef MUL_SEQ_SKIP_ZERO_EN
        mask_q <= in_mask;
`endif
      end
      // Result register only moves on entry to DONE, so it holds between jobs.
      if ((state_d == DONE) && (state_q != DONE)) p_q <= acc_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_p     = p_q;
  assign busy          = (state_q != IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: exact core model on the mul_* port, expected products
// queued at accept and popped by a monitor on each result handshake.
module tb_mul_seq_ctrl;
  import mul_seq_pkg::*;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          busy;
  logic [15:0]   mul_a, mul_b;
  logic [31:0]   mul_p;
  state_e        dbg_state;

  mul_seq_ctrl_if #(.W(W)) bus ();

  mul_seq_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .dbg_state (dbg_state)
  );

  // Exact combinational core.
  assign mul_p = 32'(mul_a) * 32'(mul_b);

  logic [63:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          ready_mode = 1;  // <0 random stalls, else out_ready = ready_mode[0]
  logic [31:0] ra, rb;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_mul(logic [31:0] a, logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  // Edges from the accept edge until out_valid is seen: one per partial product run.
  function automatic int exp_lat(logic [31:0] a, logic [31:0] b);
`ifdef MUL_SEQ_SKIP_ZERO_EN
    int n;
    n = 0;
    if (a[15:0]  != 0 && b[15:0]  != 0) n++;
    if (a[31:16] != 0 && b[15:0]  != 0) n++;
    if (a[15:0]  != 0 && b[31:16] != 0) n++;
    if (a[31:16] != 0 && b[31:16] != 0) n++;
    return n;
`else
    return 4;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (ready_mode < 0) bus.out_ready = ($urandom_range(0, 3) != 0);
      else                bus.out_ready = ready_mode[0];
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int k;
    k = 0;
    while (!bus.in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    @(posedge clk);
    exp_q.push_back(ref_mul(a, b));
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_a     = $urandom;
    bus.in_b     = $urandom;
    k = 0;
    while (!bus.out_valid && k < 12) begin
      chk("in_ready_while_busy", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      k++;
    end
    chk("latency", 64'(k), 64'(exp_lat(a, b)));
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (dbg_state != PP) chk("core_quiet", {32'd0, mul_a, mul_b}, 64'd0);
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("product", bus.out_p, e);
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int k;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy",      64'(busy),          64'd0);
    chk("rst_out_p",     bus.out_p,          64'd0);
    chk("rst_mul_ops",   {32'd0, mul_a, mul_b}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'h0001_0002, 32'h0003_0004);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(32'h0000_0005, 32'h0000_0007);
    issue(32'h0000_0000, 32'h1234_5678);
    issue(32'h8000_0000, 32'h0001_FFFF);

    // Backpressure: result must hold while the consumer stalls.
    ready_mode = 0;
    ra = 32'hCAFE_1234;
    rb = 32'h0BAD_F00D;
    issue(ra, rb);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_in_ready",  64'(bus.in_ready),  64'd0);
      chk("bp_out_p",     bus.out_p,          ref_mul(ra, rb));
      if (i == 3) begin
        bus.in_valid = 1'b1;
        bus.in_a     = 32'h1111_1111;
        bus.in_b     = 32'h2222_2222;
      end
      if (i == 4) bus.in_valid = 1'b0;
    end
    ready_mode = 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready",  64'(bus.in_ready),  64'd1);
    chk("bp_release_out_valid", 64'(bus.out_valid), 64'd0);

    // Reset during step2 of a job: nothing may come out for it.
    chk("abort_start_idle", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_a     = 32'h1357_9BDF;
    bus.in_b     = 32'h2468_ACE0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready",  64'(bus.in_ready),  64'd1);
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_busy",      64'(busy),          64'd0);
    chk("abort_out_p",     bus.out_p,          64'd0);
    chk("abort_mul_ops",   {32'd0, mul_a, mul_b}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(32'hDEAD_BEEF, 32'h1234_5678);

    // Randomized jobs with consumer stalls.
    ready_mode = -1;
    for (int j = 0; j < 1500; j++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: ra[15:0]  = '0;
        1: ra[31:16] = '0;
        2: rb[15:0]  = '0;
        3: rb[31:16] = '0;
        4: ra = '0;
        5: begin ra = 32'hFFFF_FFFF; rb = 32'hFFFF_FFFF; end
        6: begin ra[31:16] = '0; rb[31:16] = '0; end
        default: ;
      endcase
      issue(ra, rb);
    end
    ready_mode = 1;

    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
